// File: rtl/hazard_ctrl_mc_if.sv
// Signal bundle between the pipeline datapath and the hazard/forwarding controller.
// The master side is the pipeline; the slave side is hazard_ctrl_mc.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] i_if_id_rs1;
    logic [REG_AW-1:0] i_if_id_rs2;
    logic [REG_AW-1:0] i_id_ex_rs1;
    logic [REG_AW-1:0] i_id_ex_rs2;
    logic [REG_AW-1:0] i_id_ex_rd;
    logic              i_id_ex_memread;
    logic              i_id_ex_mdu;
    logic              i_mdu_done;
    logic              i_mispredict;
    logic              i_ex_mem_regwrite;
    logic [REG_AW-1:0] i_ex_mem_rd;
    logic              i_ex_mem_memread;
    logic              i_mem_wb_regwrite;
    logic [REG_AW-1:0] i_mem_wb_rd;

    logic              o_stall_pc;
    logic              o_stall_if_id;
    logic              o_stall_id_ex;
    logic              o_stall_ex_mem;
    logic              o_flush_if_id;
    logic              o_flush_id_ex;
    logic              o_flush_ex_mem;
    logic              o_flush_mem_wb;
    logic [1:0]        o_forward_a;
    logic [1:0]        o_forward_b;
    logic              o_fwd_id_a;
    logic              o_fwd_id_b;
    logic              o_busy;
    logic [CNT_W-1:0]  o_stall_count;

    modport master (
        output i_if_id_rs1, i_if_id_rs2, i_id_ex_rs1, i_id_ex_rs2, i_id_ex_rd,
               i_id_ex_memread, i_id_ex_mdu, i_mdu_done, i_mispredict,
               i_ex_mem_regwrite, i_ex_mem_rd, i_ex_mem_memread,
               i_mem_wb_regwrite, i_mem_wb_rd,
        input  o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem,
               o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
               o_forward_a, o_forward_b, o_fwd_id_a, o_fwd_id_b,
               o_busy, o_stall_count
    );

    modport slave (
        input  i_if_id_rs1, i_if_id_rs2, i_id_ex_rs1, i_id_ex_rs2, i_id_ex_rd,
               i_id_ex_memread, i_id_ex_mdu, i_mdu_done, i_mispredict,
               i_ex_mem_regwrite, i_ex_mem_rd, i_ex_mem_memread,
               i_mem_wb_regwrite, i_mem_wb_rd,
        output o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem,
               o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
               o_forward_a, o_forward_b, o_fwd_id_a, o_fwd_id_b,
               o_busy, o_stall_count
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for a 5-stage RV32 pipeline: operand forwarding,
// load-use stall, multi-cycle load freeze, MDU stall and mispredict flush.
module hazard_ctrl_mc #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    hazard_ctrl_mc_if.slave  bus
);
    localparam int LAT_W = $clog2(LOAD_LAT + 1);
    localparam logic [LAT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? LAT_W'(LOAD_LAT - 2) : '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_WAIT  = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [LAT_W-1:0]   cnt_reg, cnt_next;
    logic               ld_done_reg, ld_done_next;
    logic [CNT_W-1:0]   stall_count_reg;

    logic freeze;
    logic load_use;
    logic ld_start;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;

    // Forwarding, one lane per source operand (index 0 = rs1/a, 1 = rs2/b).
    logic [1:0][REG_AW-1:0] ex_rs;
    logic [1:0][REG_AW-1:0] id_rs;
    logic [1:0][1:0]        fwd_ex;
    logic [1:0]             fwd_id;

    assign ex_rs[0] = bus.i_id_ex_rs1;
    assign ex_rs[1] = bus.i_id_ex_rs2;
    assign id_rs[0] = bus.i_if_id_rs1;
    assign id_rs[1] = bus.i_if_id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_mem_hit;
            logic mem_wb_hit;

            // A load in MEM has no data yet, so it never feeds EX directly.
            assign ex_mem_hit = bus.i_ex_mem_regwrite && (bus.i_ex_mem_rd != '0) &&
                                (bus.i_ex_mem_rd == ex_rs[gi]) && !bus.i_ex_mem_memread;
            assign mem_wb_hit = bus.i_mem_wb_regwrite && (bus.i_mem_wb_rd != '0) &&
                                (bus.i_mem_wb_rd == ex_rs[gi]);

            assign fwd_ex[gi] = i_reset    ? 2'b00 :
                                ex_mem_hit ? 2'b10 :
                                mem_wb_hit ? 2'b01 : 2'b00;
            assign fwd_id[gi] = !i_reset && bus.i_mem_wb_regwrite &&
                                (bus.i_mem_wb_rd != '0) && (bus.i_mem_wb_rd == id_rs[gi]);
        end
    endgenerate

    assign load_use = bus.i_id_ex_memread && (bus.i_id_ex_rd != '0) &&
                      ((bus.i_id_ex_rd == bus.i_if_id_rs1) ||
                       (bus.i_id_ex_rd == bus.i_if_id_rs2));
    assign ld_start = (LOAD_LAT > 1) && bus.i_ex_mem_memread && !ld_done_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ld_done_next = ld_done_reg;
        freeze       = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (ld_start) begin
                    freeze   = 1'b1;
                    cnt_next = CNT_INIT;
                    if (LOAD_LAT == 2) begin
                        ld_done_next = 1'b1;
                    end else begin
                        state_next = ST_LD_WAIT;
                    end
                end else begin
                    ld_done_next = 1'b0;
                    if (bus.i_mispredict) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (bus.i_id_ex_mdu && !bus.i_mdu_done) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        state_next   = ST_MDU_WAIT;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
            end
            ST_LD_WAIT: begin
                // Mispredicts are ignored here; ID/EX is held and re-evaluated on release.
                freeze   = 1'b1;
                cnt_next = cnt_reg - LAT_W'(1);
                if (cnt_reg == LAT_W'(1)) begin
                    state_next   = ST_RUN;
                    ld_done_next = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (!bus.i_mdu_done) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (freeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end

        if (i_reset) begin
            stall_pc     = 1'b0;
            stall_if_id  = 1'b0;
            stall_id_ex  = 1'b0;
            stall_ex_mem = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
            flush_mem_wb = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_RUN;
            cnt_reg         <= '0;
            ld_done_reg     <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ld_done_reg <= ld_done_next;
            if (stall_pc && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.o_stall_pc     = stall_pc;
    assign bus.o_stall_if_id  = stall_if_id;
    assign bus.o_stall_id_ex  = stall_id_ex;
    assign bus.o_stall_ex_mem = stall_ex_mem;
    assign bus.o_flush_if_id  = flush_if_id;
    assign bus.o_flush_id_ex  = flush_id_ex;
    assign bus.o_flush_ex_mem = flush_ex_mem;
    assign bus.o_flush_mem_wb = flush_mem_wb;
    assign bus.o_forward_a    = fwd_ex[0];
    assign bus.o_forward_b    = fwd_ex[1];
    assign bus.o_fwd_id_a     = fwd_id[0];
    assign bus.o_fwd_id_b     = fwd_id[1];
    assign bus.o_busy         = !i_reset && (state_reg != ST_RUN);
    assign bus.o_stall_count  = stall_count_reg;
endmodule
